// File: rtl/gsensor_spi_responder.sv
// gsensor_spi_responder
//   SPI slave (4-wire, mode 3) that emulates a subset of the ADXL345 register
//   interface. An accelerometer SPI master can then be exercised against a
//   known data source. All SPI pins are oversampled on sys_clk.
// Ports
//   sys_clk, reset_n           system clock, asynchronous active-low reset
//   spi_sclk/spi_cs/spi_mosi   SPI inputs from the master (sclk idles high)
//   spi_miso, spi_miso_oe      SPI data out and its output enable
//   sample_x/y/z, sample_valid new per-axis sample with a 1-cycle strobe
//   int1                       data_ready gated by INT_ENABLE[7]
//   power_ctl, data_format     current POWER_CTL / DATA_FORMAT registers
module gsensor_spi_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic        int1,
  output logic [7:0]  power_ctl,
  output logic [7:0]  data_format
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic        sclk_prev, cs_prev;
  logic        sclk_s, cs_s, mosi_s;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [1:0]  state;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  tx_shift;
  logic        rw, mb;
  logic [5:0]  addr;
  logic        rd_flag;

  logic [7:0]  bw_rate, int_enable;
  logic [47:0] data_shadow, pend_data;
  logic        pend_valid, data_ready;

  logic [7:0]  rx_byte, rd_data;
  logic [5:0]  load_addr;
  logic        byte_done, wr_en, data_rd_done, accept;

  // Pin synchronisers plus one extra stage for edge detection.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= {SYNC_STAGES{1'b1}};
      cs_sync   <= {SYNC_STAGES{1'b1}};
      mosi_sync <= {SYNC_STAGES{1'b0}};
      sclk_prev <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign accept    = sample_valid & power_ctl[3];

  // Byte-completion decode and the read mux for the next byte to transmit.
  always_comb begin
    rx_byte      = {shift_in, mosi_s};
    byte_done    = (state != ST_IDLE) && sclk_rise && !cs_rise && (bit_cnt == 3'd7);
    wr_en        = byte_done && (state == ST_DATA) && !rw;
    data_rd_done = byte_done && (state == ST_DATA) && rw &&
                   (addr >= 6'h32) && (addr <= 6'h37);
    // The command byte supplies the first address; later bytes step or repeat.
    if (state == ST_CMD) begin
      load_addr = rx_byte[5:0];
    end else if (mb) begin
      load_addr = addr + 6'd1;
    end else begin
      load_addr = addr;
    end
    case (load_addr)
      6'h00:   rd_data = DEVID;
      6'h2C:   rd_data = bw_rate;
      6'h2D:   rd_data = power_ctl;
      6'h2E:   rd_data = int_enable;
      6'h30:   rd_data = {data_ready, 7'b0};
      6'h31:   rd_data = data_format;
      6'h32:   rd_data = data_shadow[7:0];
      6'h33:   rd_data = data_shadow[15:8];
      6'h34:   rd_data = data_shadow[23:16];
      6'h35:   rd_data = data_shadow[31:24];
      6'h36:   rd_data = data_shadow[39:32];
      6'h37:   rd_data = data_shadow[47:40];
      default: rd_data = 8'h00;
    endcase
  end

  // SPI transaction FSM: command capture, data shifting, miso drive.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      shift_in    <= 7'd0;
      tx_shift    <= 8'd0;
      rw          <= 1'b0;
      mb          <= 1'b0;
      addr        <= 6'd0;
      rd_flag     <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else if (cs_rise) begin
      // Any partial byte is simply dropped.
      state       <= ST_IDLE;
      bit_cnt     <= 3'd0;
      rd_flag     <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_CMD;
            bit_cnt <= 3'd0;
            rd_flag <= 1'b0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            shift_in <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw    <= rx_byte[7];
              mb    <= rx_byte[6];
              addr  <= rx_byte[5:0];
              state <= ST_DATA;
              if (rx_byte[7]) begin
                tx_shift    <= rd_data;
                spi_miso_oe <= 1'b1;
              end
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            shift_in <= rx_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (byte_done) begin
              addr <= load_addr;
              if (rw) begin
                tx_shift <= rd_data;
              end
              if (data_rd_done) begin
                rd_flag <= 1'b1;
              end
            end
          end else if (sclk_fall && rw) begin
            spi_miso <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register file writes, sample shadowing and the data_ready flag.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      bw_rate     <= 8'h0A;
      power_ctl   <= 8'h00;
      int_enable  <= 8'h00;
      data_format <= 8'h00;
      data_shadow <= 48'd0;
      pend_data   <= 48'd0;
      pend_valid  <= 1'b0;
      data_ready  <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr)
          6'h2C:   bw_rate     <= rx_byte;
          6'h2D:   power_ctl   <= rx_byte;
          6'h2E:   int_enable  <= rx_byte;
          6'h31:   data_format <= rx_byte;
          default: ;
        endcase
      end
      if (cs_rise) begin
        // Clear for the finished read first; a fresh sample then re-sets it.
        if (rd_flag) begin
          data_ready <= 1'b0;
        end
        if (accept) begin
          data_shadow <= {sample_z, sample_y, sample_x};
          data_ready  <= 1'b1;
          pend_valid  <= 1'b0;
        end else if (pend_valid) begin
          data_shadow <= pend_data;
          data_ready  <= 1'b1;
          pend_valid  <= 1'b0;
        end
      end else if (accept) begin
        if (state == ST_IDLE) begin
          data_shadow <= {sample_z, sample_y, sample_x};
          data_ready  <= 1'b1;
        end else begin
          pend_data  <= {sample_z, sample_y, sample_x};
          pend_valid <= 1'b1;
        end
      end
    end
  end

  assign int1 = data_ready & int_enable[7];

endmodule

// File: tb/tb_gsensor_spi_responder.sv
module tb_gsensor_spi_responder;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        spi_sclk, spi_cs, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid;
  logic        int1;
  logic [7:0]  power_ctl, data_format;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx;
  logic       oe_seen;

  gsensor_spi_responder dut (
    .sys_clk      (sys_clk),
    .reset_n      (reset_n),
    .spi_sclk     (spi_sclk),
    .spi_cs       (spi_cs),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .sample_valid (sample_valid),
    .int1         (int1),
    .power_ctl    (power_ctl),
    .data_format  (data_format)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Mode 3: drive mosi after sclk falls, sample miso just before sclk rises.
  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rxb, output logic oe_at_rise);
    rxb = 8'h00;
    oe_at_rise = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b0;
      spi_mosi = tx[7-i];
      #40;
      rxb = {rxb[6:0], spi_miso};
      oe_at_rise = spi_miso_oe;
      spi_sclk = 1'b1;
      #40;
    end
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    #80;
  endtask

  task automatic cs_end();
    #80;
    spi_cs = 1'b1;
    #100;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    logic o;
    cs_begin();
    spi_bits(a, 8, r, o);
    spi_bits(d, 8, r, o);
    cs_end();
  endtask

  task automatic read_reg(input logic [7:0] cmd, output logic [7:0] d);
    logic o;
    cs_begin();
    spi_bits(cmd, 8, d, o);
    spi_bits(8'h00, 8, d, o);
    cs_end();
  endtask

  task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x = x;
    sample_y = y;
    sample_z = z;
    sample_valid = 1'b1;
    #10;
    sample_valid = 1'b0;
    #20;
  endtask

  initial begin
    reset_n = 1'b0;
    spi_sclk = 1'b1;
    spi_cs = 1'b1;
    spi_mosi = 1'b0;
    sample_x = 16'h0000;
    sample_y = 16'h0000;
    sample_z = 16'h0000;
    sample_valid = 1'b0;
    #30;
    reset_n = 1'b1;
    #20;

    // Reset state
    chk("rst_miso", {15'd0, spi_miso}, 16'h0000);
    chk("rst_oe", {15'd0, spi_miso_oe}, 16'h0000);
    chk("rst_int1", {15'd0, int1}, 16'h0000);
    chk("rst_power_ctl", {8'd0, power_ctl}, 16'h0000);
    chk("rst_data_format", {8'd0, data_format}, 16'h0000);

    // DEVID read, oe only during the data byte
    cs_begin();
    chk("devid_oe_pre", {15'd0, spi_miso_oe}, 16'h0000);
    spi_bits(8'h80, 8, rx, oe_seen);
    chk("devid_oe_cmd", {15'd0, oe_seen}, 16'h0000);
    spi_bits(8'h00, 8, rx, oe_seen);
    chk("devid_oe_data", {15'd0, oe_seen}, 16'h0001);
    chk("devid_value", {8'd0, rx}, 16'h00E5);
    cs_end();
    chk("devid_oe_post", {15'd0, spi_miso_oe}, 16'h0000);
    chk("devid_miso_post", {15'd0, spi_miso}, 16'h0000);

    // BW_RATE reset value
    read_reg(8'hAC, rx);
    chk("bw_rate_rst", {8'd0, rx}, 16'h000A);

    // POWER_CTL write and read-back
    write_reg(8'h2D, 8'h08);
    chk("power_ctl_wr", {8'd0, power_ctl}, 16'h0008);
    read_reg(8'hAD, rx);
    chk("power_ctl_rd", {8'd0, rx}, 16'h0008);

    // Sample strobe, data_ready/int1, six-byte burst
    write_reg(8'h2E, 8'h80);
    chk("int1_before", {15'd0, int1}, 16'h0000);
    strobe(16'h1234, 16'hFF80, 16'h0100);
    chk("int1_after_strobe", {15'd0, int1}, 16'h0001);
    read_reg(8'hB0, rx);
    chk("int_source", {8'd0, rx}, 16'h0080);
    chk("int1_after_src_rd", {15'd0, int1}, 16'h0001);
    cs_begin();
    spi_bits(8'hF2, 8, rx, oe_seen);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst1_b0", {8'd0, rx}, 16'h0034);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst1_b1", {8'd0, rx}, 16'h0012);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst1_b2", {8'd0, rx}, 16'h0080);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst1_b3", {8'd0, rx}, 16'h00FF);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst1_b4", {8'd0, rx}, 16'h0000);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst1_b5", {8'd0, rx}, 16'h0001);
    chk("int1_cs_low", {15'd0, int1}, 16'h0001);
    cs_end();
    chk("int1_cleared", {15'd0, int1}, 16'h0000);

    // Strobe during a burst is held back until cs rises
    strobe(16'h1234, 16'hFF80, 16'h0100);
    cs_begin();
    spi_bits(8'hF2, 8, rx, oe_seen);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst2_b0", {8'd0, rx}, 16'h0034);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst2_b1", {8'd0, rx}, 16'h0012);
    strobe(16'h5555, 16'h0000, 16'h0000);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst2_b2", {8'd0, rx}, 16'h0080);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst2_b3", {8'd0, rx}, 16'h00FF);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst2_b4", {8'd0, rx}, 16'h0000);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst2_b5", {8'd0, rx}, 16'h0001);
    cs_end();
    chk("int1_pending_set", {15'd0, int1}, 16'h0001);
    cs_begin();
    spi_bits(8'hF2, 8, rx, oe_seen);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst3_b0", {8'd0, rx}, 16'h0055);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst3_b1", {8'd0, rx}, 16'h0055);
    spi_bits(8'h00, 8, rx, oe_seen); chk("burst3_b2", {8'd0, rx}, 16'h0000);
    cs_end();
    chk("int1_burst3_clr", {15'd0, int1}, 16'h0000);

    // Aborted DATA_FORMAT write, then a complete one
    cs_begin();
    spi_bits(8'h31, 8, rx, oe_seen);
    spi_bits(8'hFF, 5, rx, oe_seen);
    cs_end();
    chk("data_format_abort", {8'd0, data_format}, 16'h0000);
    write_reg(8'h31, 8'h0B);
    chk("data_format_wr", {8'd0, data_format}, 16'h000B);

    // Multi-byte write wrapping 0x3F -> 0x00 (read-only), samples blocked
    write_reg(8'h2D, 8'h00);
    chk("power_ctl_off", {8'd0, power_ctl}, 16'h0000);
    cs_begin();
    spi_bits(8'h7F, 8, rx, oe_seen);
    spi_bits(8'hAA, 8, rx, oe_seen);
    spi_bits(8'h55, 8, rx, oe_seen);
    cs_end();
    read_reg(8'h80, rx);
    chk("devid_after_wrap", {8'd0, rx}, 16'h00E5);
    chk("power_ctl_after_wrap", {8'd0, power_ctl}, 16'h0000);
    strobe(16'h7777, 16'h8888, 16'h9999);
    chk("int1_blocked", {15'd0, int1}, 16'h0000);
    read_reg(8'hB0, rx);
    chk("int_source_blocked", {8'd0, rx}, 16'h0000);
    read_reg(8'hB2, rx);
    chk("datax0_unchanged", {8'd0, rx}, 16'h0055);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
